lfsr_word_packer: RTL and testbench

Downstream consumer of the LFSR cell chain. Samples the serial pseudo-random bit on every clock-enable strobe, packs `WORD_W` consecutive bits into a word, attaches a per-word ones count for monobit checking, and buffers completed words in a small FIFO. Words leave on a valid/ready handshake. Words that arrive while the FIFO is full are dropped and counted.

---
 rtl/lfsr_pkg.sv | 18 +
 rtl/lfsr_sync_fifo.sv | 66 ++++++
 rtl/lfsr_word_packer.sv | 112 +++++++++++
 tb/tb_lfsr_word_packer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg
// Shared constants, types and width helpers for the LFSR word packer slice.
//   LFSR_WORD_W     : default bits per packed word
//   LFSR_FIFO_DEPTH : default word FIFO depth
//   ones_w()        : width needed to hold a ones count of 0..w
//   drop_cnt_t      : saturating dropped-word counter type
package lfsr_pkg;

    localparam int LFSR_WORD_W     = 8;
    localparam int LFSR_FIFO_DEPTH = 4;

    typedef logic [7:0] drop_cnt_t;

    function automatic int ones_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/lfsr_sync_fifo.sv
// lfsr_sync_fifo
// Single-clock circular-buffer FIFO with a separately tracked level.
// A push into a full FIFO is still accepted when a pop happens in the same
// cycle; the write lands in the slot being vacated.
// Ports:
//   ckIn, rstIn : clock, synchronous active-high reset
//   pushReq     : request to write pushData
//   pushData    : WIDTH-bit write data
//   popReq      : request to drop the head entry (ignored when empty)
//   popData     : head entry (storage at the read pointer)
//   notEmpty    : level != 0
//   pushAcc     : pushReq was accepted this cycle
//   level       : occupancy 0..DEPTH
module lfsr_sync_fifo #(
    parameter  int WIDTH = 12,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             ckIn,
    input  logic             rstIn,
    input  logic             pushReq,
    input  logic [WIDTH-1:0] pushData,
    input  logic             popReq,
    output logic [WIDTH-1:0] popData,
    output logic             notEmpty,
    output logic             pushAcc,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             popOk;

    assign notEmpty = (level != '0);
    assign popOk    = popReq && notEmpty;
    assign pushAcc  = pushReq && ((level != LVL_W'(DEPTH)) || popOk);
    assign popData  = mem[rdPtr];

    always_ff @(posedge ckIn) begin
        if (rstIn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
            // Cleared so the head output reads zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (pushAcc) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (popOk) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({pushAcc, popOk})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/lfsr_word_packer.sv
// lfsr_word_packer
// Packs WORD_W strobed serial LFSR bits into words (first bit in the MSB),
// tags each word with its ones count, and buffers words in a small FIFO.
// Words completed while the FIFO is full are dropped and counted.
// Ports:
//   ckIn, rstIn : clock, synchronous active-high reset (highest priority)
//   ckEn        : bit strobe, bitIn sampled when high
//   bitIn       : serial LFSR bit
//   clrOvf      : clears overflow and dropCnt (a same-cycle drop wins)
//   wordReady   : consumer accepts the head word
//   wordOut     : head word
//   onesOut     : ones count of wordOut
//   wordValid   : FIFO not empty
//   overflow    : sticky drop flag
//   dropCnt     : dropped-word count, saturating at 255
//   level       : FIFO occupancy
module lfsr_word_packer
    import lfsr_pkg::*;
#(
    parameter  int WORD_W = LFSR_WORD_W,
    parameter  int DEPTH  = LFSR_FIFO_DEPTH,
    localparam int ONES_W = ones_w(WORD_W),
    localparam int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              ckIn,
    input  logic              rstIn,
    input  logic              ckEn,
    input  logic              bitIn,
    input  logic              clrOvf,
    input  logic              wordReady,
    output logic [WORD_W-1:0] wordOut,
    output logic [ONES_W-1:0] onesOut,
    output logic              wordValid,
    output logic              overflow,
    output drop_cnt_t         dropCnt,
    output logic [LVL_W-1:0]  level
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam int ENT_W = WORD_W + ONES_W;

    logic [WORD_W-2:0] shReg;
    logic [CNT_W-1:0]  bitCnt;
    logic [ONES_W-1:0] onesAcc;

    logic [WORD_W-1:0] shNext;
    logic [ONES_W-1:0] onesNext;
    logic              push;
    logic              pushAcc;
    logic              drop;
    logic [ENT_W-1:0]  headEnt;

    // Full-width view of the shift; its low WORD_W-1 bits are the next shReg
    // and the whole thing is the completed word on the last bit.
    assign shNext   = {shReg, bitIn};
    assign onesNext = onesAcc + ONES_W'(bitIn);
    assign push     = ckEn && (bitCnt == CNT_W'(WORD_W - 1));
    assign drop     = push && !pushAcc;

    always_ff @(posedge ckIn) begin
        if (rstIn) begin
            shReg   <= '0;
            bitCnt  <= '0;
            onesAcc <= '0;
        end else if (ckEn) begin
            shReg <= shNext[WORD_W-2:0];
            if (push) begin
                bitCnt  <= '0;
                onesAcc <= '0;
            end else begin
                bitCnt  <= bitCnt + 1'b1;
                onesAcc <= onesNext;
            end
        end
    end

    always_ff @(posedge ckIn) begin
        if (rstIn) begin
            overflow <= 1'b0;
            dropCnt  <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clrOvf) begin
                dropCnt <= drop_cnt_t'(1);
            end else if (dropCnt != '1) begin
                dropCnt <= dropCnt + 1'b1;
            end
        end else if (clrOvf) begin
            overflow <= 1'b0;
            dropCnt  <= '0;
        end
    end

    lfsr_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) uFifo (
        .ckIn     (ckIn),
        .rstIn    (rstIn),
        .pushReq  (push),
        .pushData ({shNext, onesNext}),
        .popReq   (wordReady),
        .popData  (headEnt),
        .notEmpty (wordValid),
        .pushAcc  (pushAcc),
        .level    (level)
    );

    assign wordOut = headEnt[ENT_W-1:ONES_W];
    assign onesOut = headEnt[ONES_W-1:0];

endmodule

// File: tb/tb_lfsr_word_packer.sv
// tb_lfsr_word_packer
// Directed checks of packing, FIFO fill/drop, reset mid-word and drop counter
// saturation/clear, followed by a random run against a reference model.
module tb_lfsr_word_packer;

    logic       ckIn = 1'b0;
    logic       rstIn = 1'b1;
    logic       ckEn = 1'b0;
    logic       bitIn = 1'b0;
    logic       clrOvf = 1'b0;
    logic       wordReady = 1'b0;
    logic [7:0] wordOut;
    logic [3:0] onesOut;
    logic       wordValid;
    logic       overflow;
    logic [7:0] dropCnt;
    logic [2:0] level;

    int nTests = 0;
    int nFail  = 0;

    lfsr_word_packer dut (
        .ckIn      (ckIn),
        .rstIn     (rstIn),
        .ckEn      (ckEn),
        .bitIn     (bitIn),
        .clrOvf    (clrOvf),
        .wordReady (wordReady),
        .wordOut   (wordOut),
        .onesOut   (onesOut),
        .wordValid (wordValid),
        .overflow  (overflow),
        .dropCnt   (dropCnt),
        .level     (level)
    );

    always #5 ckIn = ~ckIn;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ckIn);
        #1;
    endtask

    task automatic doReset();
        rstIn = 1'b1; ckEn = 1'b0; bitIn = 1'b0; clrOvf = 1'b0; wordReady = 1'b0;
        cyc();
        rstIn = 1'b0;
    endtask

    // Strobe n bits of pattern, MSB first.
    task automatic sendBits(input logic [7:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            ckEn  = 1'b1;
            bitIn = pat[7 - i];
            cyc();
        end
        ckEn = 1'b0;
    endtask

    // Random-run reference model state.
    logic [7:0] q[$];
    logic [7:0] mSh;
    int         mCnt;
    int         mDrops;

    initial begin
        cyc();
        doReset();
        chk("rst_wordOut", wordOut, 8'h00);
        chk("rst_onesOut", onesOut, 0);
        chk("rst_valid", wordValid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_dropCnt", dropCnt, 0);
        chk("rst_level", level, 0);

        // Single word 1,0,1,1,0,0,1,0.
        sendBits(8'hB2, 8);
        chk("w1_word", wordOut, 8'hB2);
        chk("w1_ones", onesOut, 4);
        chk("w1_valid", wordValid, 1);
        chk("w1_level", level, 1);
        wordReady = 1'b1;
        cyc();
        wordReady = 1'b0;
        chk("w1_pop_level", level, 0);
        chk("w1_pop_valid", wordValid, 0);
        // Pop on empty has no effect.
        wordReady = 1'b1;
        cyc();
        wordReady = 1'b0;
        chk("empty_pop_level", level, 0);

        // Fill with all-ones, then drop the fifth word.
        doReset();
        for (int w = 0; w < 4; w++) sendBits(8'hFF, 8);
        chk("fill_level", level, 4);
        chk("fill_word", wordOut, 8'hFF);
        chk("fill_ones", onesOut, 8);
        chk("fill_ovf", overflow, 0);
        sendBits(8'hFF, 8);
        chk("drop_ovf", overflow, 1);
        chk("drop_cnt", dropCnt, 1);
        chk("drop_level", level, 4);

        clrOvf = 1'b1;
        cyc();
        clrOvf = 1'b0;
        chk("clr_ovf", overflow, 0);
        chk("clr_cnt", dropCnt, 0);

        // Full FIFO, completing strobe with a same-cycle pop: zero word accepted.
        sendBits(8'h00, 7);
        ckEn = 1'b1; bitIn = 1'b0; wordReady = 1'b1;
        cyc();
        ckEn = 1'b0; wordReady = 1'b0;
        chk("pp_level", level, 4);
        chk("pp_ovf", overflow, 0);
        chk("pp_cnt", dropCnt, 0);
        chk("pp_head", wordOut, 8'hFF);
        wordReady = 1'b1;
        cyc(); cyc(); cyc();
        wordReady = 1'b0;
        chk("pp_tail_word", wordOut, 8'h00);
        chk("pp_tail_ones", onesOut, 0);
        chk("pp_tail_level", level, 1);

        // Partial word, then reset (with a strobe held high) discards it.
        doReset();
        sendBits(8'hE0, 3);
        rstIn = 1'b1; ckEn = 1'b1; bitIn = 1'b1;
        cyc();
        rstIn = 1'b0; ckEn = 1'b0;
        chk("rstmid_level", level, 0);
        sendBits(8'h5A, 8);
        chk("rstmid_word", wordOut, 8'h5A);
        chk("rstmid_ones", onesOut, 4);
        chk("rstmid_level2", level, 1);

        // 4 fill words plus 300 dropped words saturate the counter.
        doReset();
        ckEn = 1'b1; bitIn = 1'b1;
        for (int i = 0; i < 304 * 8; i++) cyc();
        ckEn = 1'b0;
        chk("sat_cnt", dropCnt, 255);
        chk("sat_ovf", overflow, 1);
        clrOvf = 1'b1;
        cyc();
        clrOvf = 1'b0;
        chk("sat_clr_cnt", dropCnt, 0);
        chk("sat_clr_ovf", overflow, 0);
        sendBits(8'hFF, 7);
        ckEn = 1'b1; bitIn = 1'b1; clrOvf = 1'b1;
        cyc();
        ckEn = 1'b0; clrOvf = 1'b0;
        chk("clrdrop_cnt", dropCnt, 1);
        chk("clrdrop_ovf", overflow, 1);

        // Random run against the model.
        doReset();
        q.delete();
        mSh = '0; mCnt = 0; mDrops = 0;
        for (int i = 0; i < 10000; i++) begin
            logic       pop, push, acc;
            logic [7:0] w;
            chk("rnd_valid", wordValid, (q.size() != 0));
            chk("rnd_level", level, q.size());
            chk("rnd_drops", dropCnt, mDrops);
            if (q.size() != 0) begin
                chk("rnd_word", wordOut, q[0]);
                chk("rnd_ones", onesOut, $countones(q[0]));
            end
            ckEn      = ($urandom_range(0, 3) != 0);
            bitIn     = $urandom_range(0, 1);
            wordReady = ($urandom_range(0, 9) < 3);
            pop  = wordReady && (q.size() != 0);
            push = ckEn && (mCnt == 7);
            acc  = push && ((q.size() < 4) || pop);
            w    = {mSh[6:0], bitIn};
            if (ckEn) begin
                mSh  = w;
                mCnt = (mCnt == 7) ? 0 : mCnt + 1;
            end
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(w);
            else if (push && mDrops < 255) mDrops++;
            cyc();
        end
        ckEn = 1'b0; wordReady = 1'b0;

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
